// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : uart_pkg                                                 |
// | Shared UART constants: byte width, default guard gap and busy      |
// | timeout, and the transmit-arbiter state encoding.                  |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_BYTE_W        = 8;
  // Defaults shared with the receive side.
  localparam int UART_GAP_TICKS_DEF = 20;
  localparam int UART_BUSY_TO_DEF   = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : uart_tx_arbiter_if                                     |
// | Requester-side and serializer-side signals of the TX arbiter.      |
// | slave = arbiter view, master = environment view.                   |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  import uart_pkg::*;

  logic [N_REQ-1:0]             req;
  logic [UART_BYTE_W*N_REQ-1:0] data_in;
  logic [N_REQ-1:0]             ack;
  logic [N_REQ-1:0]             gnt;
  logic                         tx_start;
  logic [UART_BYTE_W-1:0]       tx_data;
  logic                         tx_busy;
  logic                         baud_tick;
  logic                         err;
  logic                         idle;

  modport slave (
    input  req, data_in, tx_busy, baud_tick,
    output ack, gnt, tx_start, tx_data, err, idle
  );

  modport master (
    output req, data_in, tx_busy, baud_tick,
    input  ack, gnt, tx_start, tx_data, err, idle
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : rr_pick                                                   |
// | Combinational round-robin picker: one-hot grant of the first       |
// | asserted request searching upward from (last+1) mod N_REQ.         |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    last_i,
  output logic [N_REQ-1:0] gnt_o
);

  logic [PW-1:0] idx;
  logic          found;

  // Walk the N_REQ positions after last, first hit wins.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = PW'((int'(last_i) + k) % N_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : uart_tx_arbiter                                           |
// | Round-robin arbiter sharing one UART TX serializer among N_REQ     |
// | requesters: grant, one-cycle launch, busy tracking with timeout,   |
// | then a guard gap counted in baud ticks.                            |
// | Optional macro UART_ARB_PRIO_EN: requester 0 has fixed priority.   |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int GAP_TICKS = UART_GAP_TICKS_DEF,
  parameter int BUSY_TO   = UART_BUSY_TO_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uart_tx_arbiter_if.slave        bus
);

  localparam int PW = $clog2(N_REQ);
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int TW = $clog2(BUSY_TO + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TO - 1);

  arb_state_e             state_q, state_d;
  logic [N_REQ-1:0]       gnt_q, gnt_d;
  logic [UART_BYTE_W-1:0] data_q, data_d;
  logic [PW-1:0]          last_q, last_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [TW-1:0]          to_q, to_d;
  logic                   err_d;

  logic [N_REQ-1:0]       rr_req;
  logic [N_REQ-1:0]       rr_gnt;
  logic [N_REQ-1:0]       pick;
  logic                   pick_upd;
  logic [PW-1:0]          pick_idx;
  logic [UART_BYTE_W-1:0] pick_byte;

`ifdef UART_ARB_PRIO_EN
  // Requester 0 bypasses the rotation and leaves the pointer alone.
  assign rr_req   = {bus.req[N_REQ-1:1], 1'b0};
  assign pick     = bus.req[0] ? {{(N_REQ-1){1'b0}}, 1'b1} : rr_gnt;
  assign pick_upd = ~bus.req[0];
`else
  assign rr_req   = bus.req;
  assign pick     = rr_gnt;
  assign pick_upd = 1'b1;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .req_i  (rr_req),
    .last_i (last_q),
    .gnt_o  (rr_gnt)
  );

  // Winner index and its byte, from the one-hot pick.
  always_comb begin
    pick_idx  = '0;
    pick_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        pick_idx  = PW'(i);
        pick_byte = bus.data_in[i*UART_BYTE_W +: UART_BYTE_W];
      end
    end
  end

  // Next-state logic: grant, launch, busy/timeout tracking, guard gap.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    last_d  = last_q;
    gap_d   = gap_q;
    to_d    = to_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          gnt_d   = pick;
          data_d  = pick_byte;
          if (pick_upd) last_d = pick_idx;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        to_d    = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (to_q == TO_LAST) begin
          // Serializer never picked the byte up; drop it and free the line.
          err_d   = 1'b1;
          gnt_d   = '0;
          to_d    = '0;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          gnt_d   = '0;
          state_d = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (bus.baud_tick) begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      data_q  <= '0;
      last_q  <= PW'(N_REQ - 1);
      gap_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.tx_start = (state_q == S_LAUNCH);
  assign bus.ack      = (state_q == S_LAUNCH) ? gnt_q : '0;
  assign bus.tx_data  = data_q;
  assign bus.err      = err_d;
  assign bus.idle     = (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_uart_tx_arbiter                                        |
// | Self-checking bench: event-level reference model of the arbiter,   |
// | serializer and baud-tick stimulus, directed phases plus random.    |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N   = 4;
  localparam int GAP = 20;
  localparam int TO  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ     (N),
    .GAP_TICKS (GAP),
    .BUSY_TO   (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference pick: first requester above the last winner, wrapping.
  function automatic int pick_winner(input logic [N-1:0] r, input int ptr);
`ifdef UART_ARB_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (ptr + k) % N;
`ifdef UART_ARB_PRIO_EN
      if (i == 0) continue;
`endif
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Model state: what the arbiter should be doing right now.
  int         m_ptr, m_owner, m_since, m_gap;
  bit         m_idle, m_launch, m_wait, m_frame;
  logic [7:0] m_byte;
  int         q_launch[$];

  // Serializer and tick stimulus.
  int ser_mode = 0;     // 0 normal, 1 never busy, 2 random mix
  int ser_lat  = 0;
  int ser_len  = 0;

  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ser_len     = 0;
        bus.tx_busy = 1'b0;
      end else begin
        if (bus.tx_start && (ser_mode == 0 || (ser_mode == 2 && $urandom_range(0, 7) != 0))) begin
          ser_lat = $urandom_range(0, 3);
          ser_len = $urandom_range(2, 10);
        end
        if (ser_len > 0) begin
          if (ser_lat > 0) begin
            ser_lat--;
            bus.tx_busy = 1'b0;
          end else begin
            bus.tx_busy = 1'b1;
            ser_len--;
          end
        end else begin
          bus.tx_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.baud_tick = ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor: compare this cycle against the model, then advance the model.
  always @(negedge clk) begin : mon
    logic [N-1:0] eg;
    int w;
    if (!rst_n) begin
      m_ptr = N - 1; m_owner = -1; m_since = 0; m_gap = 0;
      m_idle = 1; m_launch = 0; m_wait = 0; m_frame = 0; m_byte = 8'h00;
    end else begin
      eg = '0;
      if (m_owner >= 0) eg[m_owner] = 1'b1;
      check("idle", bus.idle, m_idle);
      check("tx_start", bus.tx_start, m_launch);
      check("gnt", bus.gnt, eg);
      check("ack", bus.ack, m_launch ? eg : '0);
      check("err", bus.err, (m_wait && !bus.tx_busy && m_since == TO));
      if (m_launch || m_wait || m_frame) check("tx_data", bus.tx_data, m_byte);
      for (int i = 0; i < N; i++) if (bus.ack[i]) q_launch.push_back(i);

      if (m_idle) begin
        if (bus.req != '0) begin
          w = pick_winner(bus.req, m_ptr);
          m_owner = w;
          m_byte  = bus.data_in[w*8 +: 8];
`ifdef UART_ARB_PRIO_EN
          if (!bus.req[0]) m_ptr = w;
`else
          m_ptr = w;
`endif
          m_idle   = 0;
          m_launch = 1;
        end
      end else if (m_launch) begin
        m_launch = 0; m_wait = 1; m_since = 1;
      end else if (m_wait) begin
        if (bus.tx_busy) begin
          m_wait = 0; m_frame = 1;
        end else if (m_since == TO) begin
          m_wait = 0; m_owner = -1; m_idle = 1;
        end else begin
          m_since++;
        end
      end else if (m_frame) begin
        if (!bus.tx_busy) begin
          m_frame = 0; m_owner = -1;
          if (GAP == 0) m_idle = 1; else m_gap = GAP;
        end
      end else if (m_gap > 0) begin
        if (bus.baud_tick) begin
          m_gap--;
          if (m_gap == 0) m_idle = 1;
        end
      end
    end
  end

`ifdef UART_ARB_PRIO_EN
  int exp_order[5] = '{0, 0, 0, 0, 0};
`else
  int exp_order[5] = '{0, 1, 2, 3, 0};
`endif

  initial begin
    int  run;
    bit  hit;
    bus.req     = '0;
    bus.data_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_idle", bus.idle, 1);
    check("rst_gnt", bus.gnt, 0);
    check("rst_start", bus.tx_start, 0);
    check("rst_txdata", bus.tx_data, 8'h00);
    check("rst_err", bus.err, 0);
    rst_n = 1'b1;

    // Single requester, byte A5 on lane 2
    ser_mode = 0;
    bus.data_in = (8*N)'($urandom);
    bus.data_in[23:16] = 8'hA5;
    bus.req = 4'b0100;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (bus.ack[2]) bus.req = '0;
    end

    // Busy timeout, then a second requester granted without a gap
    ser_mode = 1;
    bus.req  = 4'b0010;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (bus.ack[1]) bus.req = 4'b1000;
      if (bus.ack[3]) bus.req = '0;
    end

    // Asynchronous reset in the middle of a frame
    ser_mode = 0;
    bus.req  = 4'b0001;
    run = 0;
    hit = 0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(posedge clk); #1;
      run = (bus.tx_busy && bus.gnt != '0) ? run + 1 : 0;
      if (run >= 3) hit = 1;
    end
    check("frame_reached", hit, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", bus.gnt, 0);
    check("arst_start", bus.tx_start, 0);
    check("arst_idle", bus.idle, 1);
    check("arst_ack", bus.ack, 0);
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fairness from reset: all requesting, bytes 11/22/33/44
    bus.data_in = 32'h4433_2211;
    bus.req     = 4'b1111;
    q_launch.delete();
    repeat (800) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++)
      check("order", (k < q_launch.size()) ? q_launch[k] : 99, exp_order[k]);

    // Requester 0 absent: 1 and 3 share the line
    bus.req = 4'b1010;
    repeat (400) @(posedge clk);
    #1;

    // Randomized traffic
    ser_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 7) == 0) bus.req = N'($urandom);
      bus.data_in = (8*N)'($urandom);
    end

    bus.req = '0;
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit serializer between N byte-producing requesters.
- Grants access round-robin and latches the winner's byte.
- Launches the byte into the serializer with a one-cycle start strobe, tracks the serializer's busy flag to frame completion, then enforces an inter-frame guard gap counted in baud ticks before the next grant.
- Sits between the protocol/command logic and the shared uart_tx datapath; it runs on the same bit-rate tick that feeds the receive-side oversampling counters.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GAP_TICKS, 20, baud ticks of idle line enforced after each frame (0 disables the gap).
- BUSY_TO, 16, clk cycles allowed between tx_start and tx_busy rising before a launch error.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester transmit request, level.
- data_in  in  8*N_REQ  byte per requester; requester i uses bits [8i+7:8i].
- ack  out  N_REQ  one-cycle pulse: requester's byte has been launched.
- gnt  out  N_REQ  one-hot current owner of the serializer, zero when idle.
- tx_start  out  1  one-cycle launch strobe to the serializer.
- tx_data  out  8  byte to the serializer, stable from tx_start until tx_busy falls.
- tx_busy  in  1  serializer framing in progress.
- baud_tick  in  1  one-cycle bit-rate pulse.
- err  out  1  one-cycle pulse on busy-timeout.
- idle  out  1  high in S_IDLE only.

Behaviour:
- Reset (rst=0, asynchronous): state=S_IDLE; gnt, ack, tx_start, err=0; tx_data=8'h00; idle=1; last-grant pointer=N_REQ-1, so requester 0 wins first; gap and timeout counters=0.
- FSM states: S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_GAP.
- S_IDLE:
  - If req != 0, pick the first asserted req searching upward from (last+1) mod N_REQ.
  - Register gnt, copy the winner's byte to tx_data, update the last pointer, go to S_LAUNCH.
  - If req == 0, stay.
- S_LAUNCH (exactly one cycle):
  - tx_start=1 and ack[winner]=1 in this cycle.
  - Clear the timeout counter, go to S_WAIT_BUSY.
  - Latency: req sampled in S_IDLE at edge n gives tx_start high in cycle n+1.
- S_WAIT_BUSY:
  - tx_busy=1 goes to S_WAIT_DONE.
  - Otherwise increment the timeout counter.
  - When the counter reaches BUSY_TO: err pulse, gnt=0, go to S_IDLE without a gap. The byte is lost; ack has already been issued.
- S_WAIT_DONE: when tx_busy=0, go to S_GAP, or to S_IDLE if GAP_TICKS=0. gnt is held throughout.
- S_GAP:
  - gnt=0.
  - Count baud_tick pulses. At the GAP_TICKS-th tick, clear the counter and go to S_IDLE.
  - Requests arriving here are held off; they are not lost, because req is a level.
- Handshake rules:
  - Data is captured at grant, so the requester may change data_in after ack.
  - req still high in the cycle after ack is a new request.
  - Dropping req between grant and ack does not cancel the launch.
- Simultaneous events:
  - tx_busy already high in S_LAUNCH is accepted on the next cycle.
  - baud_tick coincident with the S_WAIT_DONE exit is not counted toward the gap.
- Widths:
  - Pointer is $clog2(N_REQ) bits, wraps modulo N_REQ.
  - Gap counter is sized for GAP_TICKS; timeout counter is sized for BUSY_TO; neither overflows.
- Reset mid-frame aborts immediately. The serializer is not signalled; the system is responsible for resetting it as well.

Optional Feature:
- Macro UART_ARB_PRIO_EN.
- Defined: requester 0 is high priority. If req[0]=1 in S_IDLE it wins regardless of the pointer, and the pointer is not updated. Other requesters rotate among themselves.
- Undefined: pure round-robin over all N_REQ.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams S_IDLE..S_GAP;
  - UART_BYTE_W=8;
  - default GAP_TICKS/BUSY_TO constants, shared with the rx side.
- One sub-module rr_pick (combinational): inputs req, last; output one-hot grant. It is reused by future arbiters.

Test Plan:
- Single requester: req=4'b0100, data_in byte2=8'hA5, serializer model busy 10 cycles after start → tx_start 1 cycle after req, tx_data=A5, ack=4'b0100 for 1 cycle, gnt=4'b0100 until busy falls, idle again after 20 baud_ticks.
- Fairness: req=4'b1111 held, bytes 11/22/33/44 → launch order 0,1,2,3,0; no tx_start within the 20-tick gap.
- Timeout: tx_busy tied 0 → err pulses exactly 16 cycles after tx_start, gnt=0, next request granted with no gap.
- Reset in S_WAIT_DONE: rst low asynchronously mid-frame → gnt=0, tx_start=0, idle=1 without waiting for clk; first grant after release goes to requester 0.
- UART_ARB_PRIO_EN defined: req=4'b1011 held → order 0,0,0... while req[0] is high; with req[0] dropped, 1 then 3 alternate.
- GAP_TICKS=0, req=4'b0001 held → back-to-back frames, tx_start 2 cycles after tx_busy falls.
